// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor control FSM with memory wait timeout
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instruction,
    input  logic       mem_ready,
    output logic       pc_increment,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_to_reg,
    output logic       reg_a_to_mem,
    output logic       reg_b_to_mem,
    output logic       read_en,
    output logic [1:0] reg_write_address,
    output logic [7:0] ir,
    output logic       halted,
    output logic       mem_timeout,
    output logic       illegal_op,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_RD_A = 4'b0101;
    localparam logic [3:0] OP_RD_B = 4'b0110;
    localparam logic [3:0] OP_WR_A = 4'b0111;
    localparam logic [3:0] OP_WR_B = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // The last wait count at which a still-pending access gives up.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    logic [3:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;

    logic [3:0] op;
    logic       is_nop, is_alu, is_rd, is_wr, is_halt, is_illegal;

    // Opcode classification from the latched instruction register.
    always_comb begin
        op         = ir_q[7:4];
        is_nop     = (op == OP_NOP);
        is_alu     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_NOT);
        is_rd      = (op == OP_RD_A) || (op == OP_RD_B);
        is_wr      = (op == OP_WR_A) || (op == OP_WR_B);
        is_halt    = (op == OP_HALT);
        is_illegal = !(is_nop || is_alu || is_rd || is_wr || is_halt);
    end

    // State, instruction register, retire counter, wait counter and timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 8'h00;
            retired_q <= 8'h00;
            wait_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; run and mem_ready only steer transitions, never outputs.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + 8'd1;
                end else if (is_alu) begin
                    state_d = S_EXEC;
                end else if (is_rd || is_wr) begin
                    state_d = S_MEM;
                    wait_d  = 4'd0;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 8'd1;
            end
            S_MEM: begin
                // A ready on the final wait cycle still completes the access.
                if (mem_ready) begin
                    if (is_rd) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 8'd1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                    wait_d    = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 8'd1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath controls decoded from state and ir only.
    always_comb begin
        pc_increment      = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        reg_write         = 1'b0;
        mem_to_reg        = 1'b0;
        alu_to_reg        = 1'b0;
        reg_a_to_mem      = 1'b0;
        reg_b_to_mem      = 1'b0;
        read_en           = 1'b0;
        reg_write_address = 2'b00;
        halted            = 1'b0;
        illegal_op        = 1'b0;
        case (state_q)
            S_FETCH: begin
                pc_increment = 1'b1;
            end
            S_DECODE: begin
                read_en    = is_alu || is_wr;
                illegal_op = is_illegal;
            end
            S_EXEC: begin
                read_en           = 1'b1;
                alu_to_reg        = 1'b1;
                reg_write         = 1'b1;
                reg_write_address = ir_q[1:0];
            end
            S_MEM: begin
                if (is_rd) begin
                    mem_read = 1'b1;
                end else if (op == OP_WR_A) begin
                    mem_write    = 1'b1;
                    reg_a_to_mem = 1'b1;
                    read_en      = 1'b1;
                end else if (op == OP_WR_B) begin
                    mem_write    = 1'b1;
                    reg_b_to_mem = 1'b1;
                    read_en      = 1'b1;
                end
            end
            S_WB: begin
                mem_to_reg        = 1'b1;
                reg_write         = 1'b1;
                reg_write_address = (op == OP_RD_B) ? 2'b01 : 2'b00;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_timeout = timeout_q;
    assign ir          = ir_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] instruction;
    logic       mem_ready;
    logic       pc_increment, mem_read, mem_write, reg_write, mem_to_reg;
    logic       alu_to_reg, reg_a_to_mem, reg_b_to_mem, read_en;
    logic [1:0] reg_write_address;
    logic [7:0] ir;
    logic       halted, mem_timeout, illegal_op;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk               (clk),
        .reset             (reset),
        .run               (run),
        .instruction       (instruction),
        .mem_ready         (mem_ready),
        .pc_increment      (pc_increment),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .reg_write         (reg_write),
        .mem_to_reg        (mem_to_reg),
        .alu_to_reg        (alu_to_reg),
        .reg_a_to_mem      (reg_a_to_mem),
        .reg_b_to_mem      (reg_b_to_mem),
        .read_en           (read_en),
        .reg_write_address (reg_write_address),
        .ir                (ir),
        .halted            (halted),
        .mem_timeout       (mem_timeout),
        .illegal_op        (illegal_op),
        .retired           (retired)
    );

    // Packed view of every control and status bit.
    logic [13:0] ctrl;
    assign ctrl = {pc_increment, mem_read, mem_write, reg_write, mem_to_reg, alu_to_reg,
                   reg_a_to_mem, reg_b_to_mem, read_en, reg_write_address,
                   halted, mem_timeout, illegal_op};

    localparam logic [13:0] C_NONE = 14'h0000;
    localparam logic [13:0] C_PC   = 14'h2000;
    localparam logic [13:0] C_MR   = 14'h1000;
    localparam logic [13:0] C_MW   = 14'h0800;
    localparam logic [13:0] C_RW   = 14'h0400;
    localparam logic [13:0] C_M2R  = 14'h0200;
    localparam logic [13:0] C_A2R  = 14'h0100;
    localparam logic [13:0] C_RA2M = 14'h0080;
    localparam logic [13:0] C_RB2M = 14'h0040;
    localparam logic [13:0] C_RE   = 14'h0020;
    localparam logic [13:0] C_RWA2 = 14'h0010;
    localparam logic [13:0] C_RWA1 = 14'h0008;
    localparam logic [13:0] C_HLT  = 14'h0004;
    localparam logic [13:0] C_TMO  = 14'h0002;
    localparam logic [13:0] C_ILL  = 14'h0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reset, release with run=1 and the given instruction, land in FETCH.
    task automatic start(input logic [7:0] instr);
        reset       = 1'b1;
        run         = 1'b0;
        mem_ready   = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        run         = 1'b1;
        instruction = instr;
        @(negedge clk);
        check("start_fetch", ctrl, C_PC);
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b1;
        instruction = 8'h00;
        mem_ready   = 1'b1;

        // NOP then HALT from reset
        repeat (2) @(negedge clk);
        check("rst_ctrl", ctrl, C_NONE);
        check("rst_ir", ir, 8'h00);
        check("rst_retired", retired, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("nh_c1_fetch", ctrl, C_PC);
        @(negedge clk);
        check("nh_c2_decode", ctrl, C_NONE);
        check("nh_c2_ir", ir, 8'h00);
        instruction = 8'hF0;
        @(negedge clk);
        check("nh_c3_fetch", ctrl, C_PC);
        check("nh_c3_retired", retired, 8'h01);
        @(negedge clk);
        check("nh_c4_decode", ctrl, C_NONE);
        check("nh_c4_ir", ir, 8'hF0);
        @(negedge clk);
        check("nh_c5_halted", ctrl, C_HLT);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check("halt_sticky", ctrl, C_HLT);
        check("halt_retired", retired, 8'h01);

        // ADD r2 with run dropped mid-instruction
        start(8'h16);
        @(negedge clk);
        check("add_decode", ctrl, C_RE);
        check("add_ir", ir, 8'h16);
        run = 1'b0;
        @(negedge clk);
        check("add_exec", ctrl, C_RE | C_A2R | C_RW | C_RWA2);
        instruction = 8'hF0;
        @(negedge clk);
        check("add_fetch", ctrl, C_PC);
        check("add_retired", retired, 8'h01);

        // RD_B with three wait cycles; ready during DECODE must be ignored
        start(8'h63);
        @(negedge clk);
        check("rdb_decode", ctrl, C_NONE);
        mem_ready = 1'b1;
        @(negedge clk);
        check("rdb_mem1", ctrl, C_MR);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rdb_mem2", ctrl, C_MR);
        @(negedge clk);
        check("rdb_mem3", ctrl, C_MR);
        @(negedge clk);
        check("rdb_mem4", ctrl, C_MR);
        mem_ready = 1'b1;
        @(negedge clk);
        check("rdb_wb", ctrl, C_M2R | C_RW | C_RWA1);
        mem_ready   = 1'b0;
        instruction = 8'hF0;
        @(negedge clk);
        check("rdb_fetch_c8", ctrl, C_PC);
        check("rdb_retired", retired, 8'h01);

        // WR_A with mem_ready stuck low: timeout after 15 MEM cycles
        start(8'h75);
        @(negedge clk);
        check("wra_decode", ctrl, C_RE);
        instruction = 8'hF0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("wra_mem%0d", i + 1), ctrl, C_MW | C_RA2M | C_RE);
        end
        @(negedge clk);
        check("wra_timeout_fetch", ctrl, C_PC | C_TMO);
        check("wra_retired", retired, 8'h00);
        @(negedge clk);
        check("wra_timeout_clear", ctrl, C_NONE);

        // WR_A with ready arriving on the final wait cycle: no timeout
        start(8'h74);
        @(negedge clk);
        check("wrl_decode", ctrl, C_RE);
        instruction = 8'hF0;
        repeat (14) @(negedge clk);
        check("wrl_mem14", ctrl, C_MW | C_RA2M | C_RE);
        @(negedge clk);
        check("wrl_mem15", ctrl, C_MW | C_RA2M | C_RE);
        mem_ready = 1'b1;
        @(negedge clk);
        check("wrl_fetch", ctrl, C_PC);
        check("wrl_retired", retired, 8'h01);
        mem_ready = 1'b0;

        // Illegal opcode
        start(8'h9A);
        @(negedge clk);
        check("ill_decode", ctrl, C_ILL);
        check("ill_ir", ir, 8'h9A);
        instruction = 8'hF0;
        @(negedge clk);
        check("ill_fetch", ctrl, C_PC);
        check("ill_retired", retired, 8'h00);
        @(negedge clk);
        check("ill_pulse_end", ctrl, C_NONE);

        // Reset pulse during WR_B memory wait
        start(8'h81);
        @(negedge clk);
        check("wrb_decode", ctrl, C_RE);
        @(negedge clk);
        check("wrb_mem", ctrl, C_MW | C_RB2M | C_RE);
        #2;
        reset = 1'b1;
        #1;
        check("wrb_async_ctrl", ctrl, C_NONE);
        check("wrb_async_ir", ir, 8'h00);
        check("wrb_async_retired", retired, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        repeat (3) @(negedge clk);
        check("wrb_idle_hold", ctrl, C_NONE);
        run         = 1'b1;
        instruction = 8'h81;
        @(negedge clk);
        check("wrb_restart_fetch", ctrl, C_PC);
        @(negedge clk);
        check("wrb2_decode", ctrl, C_RE);
        mem_ready = 1'b1;
        @(negedge clk);
        check("wrb2_mem", ctrl, C_MW | C_RB2M | C_RE);
        instruction = 8'hF0;
        @(negedge clk);
        check("wrb2_fetch", ctrl, C_PC);
        check("wrb2_retired", retired, 8'h01);
        mem_ready = 1'b0;

        // Retire counter wrap over 256 NOPs
        start(8'h00);
        repeat (510) @(negedge clk);
        check("wrap_255", retired, 8'hFF);
        check("wrap_fetch", ctrl, C_PC);
        repeat (2) @(negedge clk);
        check("wrap_0", retired, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, 15, maximum data-memory wait cycles before abort (1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: run  input  1  level; permits leaving IDLE.
REQ-005 Port: instruction  input  8  instruction-memory output; [7:4] opcode, [3:2] rs, [1:0] rd/addr-low.
REQ-006 Port: mem_ready  input  1  data memory has completed the current access.
REQ-007 Ports: pc_increment, mem_read, mem_write, reg_write, mem_to_reg, alu_to_reg, reg_a_to_mem, reg_b_to_mem, read_en  output  1 each  datapath controls.
REQ-008 Port: reg_write_address  output  2  destination register index.
REQ-009 Port: ir  output  8  latched instruction register.
REQ-010 Ports: halted, mem_timeout, illegal_op  output  1 each  status.
REQ-011 Port: retired  output  8  retired-instruction count.

Function
REQ-012 Opcodes: NOP 0000, ADD 0001, SUB 0010, AND 0011, NOT 0100, RD_A 0101, RD_B 0110, WR_A 0111, WR_B 1000, HALT 1111; 1001-1110 illegal.
REQ-013 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary at implementer's choice.
REQ-014 All control outputs are decoded from state and ir only; no combinational path from run, instruction or mem_ready to any output.
REQ-015 IDLE: all controls 0; run=1 -> FETCH, else stay.
REQ-016 FETCH: pc_increment=1; ir <= instruction at cycle end; -> DECODE.
REQ-017 DECODE: read_en=1 for ALU and WR ops, else 0; NOP -> FETCH (retired+1); ALU op -> EXEC; RD/WR op -> MEM; HALT -> HALT; illegal -> FETCH with illegal_op=1 for that cycle only, not retired.
REQ-018 EXEC (1 cycle): read_en=1, alu_to_reg=1, reg_write=1, reg_write_address=ir[1:0]; -> FETCH, retired+1.
REQ-019 MEM, RD op: mem_read=1; WR_A: mem_write=1, reg_a_to_mem=1, read_en=1; WR_B: mem_write=1, reg_b_to_mem=1, read_en=1; signals held constant every MEM cycle.
REQ-020 MEM exit: mem_ready=1 -> WB for RD, -> FETCH (retired+1) for WR; wait counter cleared on MEM entry.
REQ-021 MEM wait: mem_ready=0 increments wait counter; counter reaching WAIT_MAX with mem_ready=0 -> FETCH, mem_timeout=1 for one cycle, instruction not retired, no register write.
REQ-022 mem_ready=1 on the same edge the counter would reach WAIT_MAX: ready wins, no timeout.
REQ-023 WB (1 cycle): mem_to_reg=1, reg_write=1, reg_write_address=00 for RD_A, 01 for RD_B; -> FETCH, retired+1.
REQ-024 reg_write_address=00 in every state where reg_write=0.
REQ-025 HALT: all controls 0, halted=1; sticky until reset; run ignored.
REQ-026 run is sampled only in IDLE; deasserting run mid-instruction has no effect.
REQ-027 mem_to_reg and alu_to_reg never both 1; mem_read and mem_write never both 1; reg_a_to_mem and reg_b_to_mem never both 1.
REQ-028 retired wraps 255 -> 0 without flag.
REQ-029 Latency from FETCH entry to next FETCH: NOP 2, ALU 3, WR 3+waits, RD 4+waits cycles.
REQ-030 mem_ready outside MEM is ignored.

Reset
REQ-031 reset=1 forces, asynchronously: state IDLE, ir 00, retired 00, wait counter 0, every output 0.
REQ-032 reset asserted mid-MEM drops mem_write/mem_read within the same cycle, no register write occurs; after release, first FETCH requires run=1.

Verification
REQ-033 reset, run=1, program NOP,HALT -> FETCH at cycle 1, DECODE 2, FETCH 3, DECODE 4, halted=1 from cycle 5, retired=01.
REQ-034 ADD ir=0x16 -> EXEC cycle shows reg_write=1, alu_to_reg=1, reg_write_address=10, read_en=1; retired increments by 1.
REQ-035 RD_B ir=0x63, mem_ready low 3 cycles then high -> mem_read=1 for 4 cycles, then WB with reg_write_address=01, mem_to_reg=1; total 7 cycles.
REQ-036 WR_A ir=0x75, mem_ready held 0 -> mem_write=1 for 15 cycles, mem_timeout pulse, FETCH next, retired unchanged.
REQ-037 ir=0x9A (illegal) -> illegal_op one-cycle pulse in DECODE, no control asserted, FETCH next, retired unchanged.
REQ-038 reset pulsed during WR_B MEM wait -> mem_write and reg_b_to_mem 0 immediately, all outputs 0, IDLE held while run=0.
